// File: rtl/flopr_pipe.sv
// DEPTH-stage register chain with per-stage valid bits, stall, flush, bubble
// insertion and a registered occupancy count.
module flopr_pipe #(
  parameter int             N         = 64,
  parameter int             DEPTH     = 3,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic [N-1:0]                 d,
  input  logic                         d_valid,
  output logic [N-1:0]                 q,
  output logic                         q_valid,
  output logic [N*DEPTH-1:0]           tap,
  output logic [DEPTH-1:0]             tap_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [N-1:0]   data_q  [DEPTH];
  logic [N-1:0]   data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OW-1:0]  occ_q;
  logic [OW-1:0]  occ_d;

  // Next state: flush beats advance, advance beats hold. Bubbles load
  // RESET_VAL so an undriven d never propagates into the chain.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = data_q[k];
    end
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_d[k] = RESET_VAL;
      end
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      data_d[0]  = d_valid ? d : RESET_VAL;
      valid_d[0] = d_valid;
      // One in, one out: modular arithmetic stays exact because 0 <= occ <= DEPTH.
      occ_d = occ_q + OW'(d_valid) - OW'(valid_q[DEPTH-1]);
    end else begin
      occ_d = occ_q;
    end
  end

  // Stage registers, valid bits and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    assign tap[k*N +: N] = data_q[k];
  end

  assign q         = data_q[DEPTH-1];
  assign q_valid   = valid_q[DEPTH-1];
  assign tap_valid = valid_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_flopr_pipe.sv
// Scoreboard bench for flopr_pipe: a 64x3 instance and an 8x1 instance with
// a non-zero reset value; monitors pop expected items as they leave the pipe.
module tb_flopr_pipe;

  logic         clk;
  logic         reset0, en0, flush0, dv0;
  logic [63:0]  d0;
  logic [63:0]  q0;
  logic         qv0;
  logic [191:0] tap0;
  logic [2:0]   tapv0;
  logic [1:0]   occ0;

  logic         reset1, en1, flush1, dv1;
  logic [7:0]   d1;
  logic [7:0]   q1;
  logic         qv1;
  logic [7:0]   tap1;
  logic [0:0]   tapv1;
  logic [0:0]   occ1;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp0 [$];
  logic [7:0]  exp1 [$];

  flopr_pipe #(.N(64), .DEPTH(3), .RESET_VAL(64'h0)) u_dut0 (
    .clk(clk), .reset(reset0), .en(en0), .flush(flush0), .d(d0), .d_valid(dv0),
    .q(q0), .q_valid(qv0), .tap(tap0), .tap_valid(tapv0), .occ(occ0)
  );

  flopr_pipe #(.N(8), .DEPTH(1), .RESET_VAL(8'hA5)) u_dut1 (
    .clk(clk), .reset(reset1), .en(en1), .flush(flush1), .d(d1), .d_valid(dv1),
    .q(q1), .q_valid(qv1), .tap(tap1), .tap_valid(tapv1), .occ(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic e, input logic f, input logic v, input logic [63:0] dd);
    en0 = e; flush0 = f; dv0 = v; d0 = dd;
    if (reset0 && e && !f && v) exp0.push_back(dd);
    tick();
  endtask

  task automatic drive1(input logic e, input logic f, input logic v, input logic [7:0] dd);
    en1 = e; flush1 = f; dv1 = v; d1 = dd;
    if (reset1 && e && !f && v) exp1.push_back(dd);
    tick();
  endtask

  // Monitor for the 64x3 pipe: one pop per advancing edge that presents a valid item.
  initial begin
    logic a;
    forever begin
      @(posedge clk);
      a = reset0 && en0 && !flush0;
      @(negedge clk);
      if (a) begin
        if (qv0 === 1'b1) begin
          if (exp0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL q0_unexpected: got %h expected no valid item", q0);
          end else begin
            chk("q0_data", {128'h0, q0}, {128'h0, exp0.pop_front()});
          end
        end else begin
          chk("q0_bubble", {128'h0, q0}, 192'h0);
        end
      end
    end
  end

  // Monitor for the 8x1 pipe.
  initial begin
    logic a;
    forever begin
      @(posedge clk);
      a = reset1 && en1 && !flush1;
      @(negedge clk);
      if (a) begin
        if (qv1 === 1'b1) begin
          if (exp1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL q1_unexpected: got %h expected no valid item", q1);
          end else begin
            chk("q1_data", {184'h0, q1}, {184'h0, exp1.pop_front()});
          end
        end else begin
          chk("q1_bubble", {184'h0, q1}, {184'h0, 8'hA5});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] vec [10];
    logic [4:0]  dvpat;
    int          idx;
    vec[0] = 64'h0123_4567_89AB_CDEF; vec[1] = 64'hFEDC_BA98_7654_3210;
    vec[2] = 64'h0000_0000_0000_0001; vec[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    vec[4] = 64'h8000_0000_0000_0000; vec[5] = 64'h5555_AAAA_5555_AAAA;
    vec[6] = 64'h1357_9BDF_2468_ACE0; vec[7] = 64'hCAFE_F00D_1234_5678;
    vec[8] = 64'h0F0F_0F0F_F0F0_F0F0; vec[9] = 64'h7FFF_FFFF_FFFF_FFFE;
    dvpat = 5'b01101;

    reset0 = 1'b0; en0 = 1'b1; flush0 = 1'b0; dv0 = 1'b1; d0 = 64'hDEAD_BEEF;
    reset1 = 1'b0; en1 = 1'b1; flush1 = 1'b0; dv1 = 1'b1; d1 = 8'h3C;

    // T1: reset held for 5 edges with live inputs
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_q", {128'h0, q0}, 192'h0);
      chk("t1_qv", {191'h0, qv0}, 192'h0);
      chk("t1_occ", {190'h0, occ0}, 192'h0);
      chk("t6_rst_q", {184'h0, q1}, {184'h0, 8'hA5});
      chk("t6_rst_qv", {191'h0, qv1}, 192'h0);
    end
    reset0 = 1'b1;
    drive0(1'b1, 1'b0, 1'b1, 64'h11);
    drive0(1'b1, 1'b0, 1'b1, 64'h22);
    chk("t1_occ_fill", {190'h0, occ0}, 192'd2);
    #2 reset0 = 1'b0;
    #1;
    chk("t1_async_tapv", {189'h0, tapv0}, 192'h0);
    chk("t1_async_occ", {190'h0, occ0}, 192'h0);
    chk("t1_async_tap", tap0, 192'h0);
    exp0.delete();
    reset0 = 1'b1;
    drive0(1'b1, 1'b1, 1'b1, 64'h33);
    chk("t1_relflush_tapv", {189'h0, tapv0}, 192'h0);
    chk("t1_relflush_occ", {190'h0, occ0}, 192'h0);

    // T2: fill and drain
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 1'b0, 1'b1, vec[i]);
      chk("t2_occ_fill", {190'h0, occ0}, (i == 0) ? 192'd1 : (i == 1) ? 192'd2 : 192'd3);
    end
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 1'b0, 1'b0, 64'hBAD0_0000 + 64'(i));
      chk("t2_occ_drain", {190'h0, occ0}, 192'd2 - 192'(i));
    end
    chk("t2_q_drained", {128'h0, q0}, 192'h0);

    // T3: stall with d changing
    drive0(1'b1, 1'b0, 1'b1, 64'hA1);
    drive0(1'b1, 1'b0, 1'b1, 64'hA2);
    for (int i = 0; i < 4; i++) begin
      drive0(1'b0, 1'b0, 1'b1, 64'hEE00 + 64'(i));
      chk("t3_tap", tap0, {64'h0, 64'hA1, 64'hA2});
      chk("t3_tapv", {189'h0, tapv0}, 192'b011);
      chk("t3_occ", {190'h0, occ0}, 192'd2);
    end
    drive0(1'b1, 1'b0, 1'b1, 64'hA3);
    drive0(1'b1, 1'b0, 1'b1, 64'hA4);
    drive0(1'b1, 1'b0, 1'b1, 64'hA5);
    for (int i = 0; i < 3; i++) drive0(1'b1, 1'b0, 1'b0, 64'h0);

    // T4: flush wins over enable on a full pipe
    drive0(1'b1, 1'b0, 1'b1, 64'hF1);
    drive0(1'b1, 1'b0, 1'b1, 64'hF2);
    drive0(1'b1, 1'b0, 1'b1, 64'hF3);
    chk("t4_full_occ", {190'h0, occ0}, 192'd3);
    chk("t4_full_tapv", {189'h0, tapv0}, 192'b111);
    drive0(1'b1, 1'b1, 1'b1, 64'hF4);
    chk("t4_tapv", {189'h0, tapv0}, 192'h0);
    chk("t4_occ", {190'h0, occ0}, 192'h0);
    chk("t4_q", {128'h0, q0}, 192'h0);
    exp0.delete();
    for (int i = 0; i < 3; i++) drive0(1'b1, 1'b0, 1'b0, 64'h0);

    // T5: bubble pattern 1,0,1,1,0 then X-data bubbles
    for (int j = 0; j < 7; j++) begin
      if (j < 5) drive0(1'b1, 1'b0, dvpat[j], 64'(j + 1));
      else       drive0(1'b1, 1'b0, 1'b0, 64'hx);
      if (j >= 2) begin
        idx = j - 2;
        chk("t5_qv", {191'h0, qv0}, {191'h0, dvpat[idx]});
        chk("t5_q", {128'h0, q0}, dvpat[idx] ? 192'(idx + 1) : 192'h0);
      end
    end
    chk("t5_tap_x", tap0, 192'h0);
    chk("t5_occ", {190'h0, occ0}, 192'h0);
    en0 = 1'b0;

    // T6: N=8, DEPTH=1, RESET_VAL=A5
    reset1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive1(1'b1, 1'b0, 1'b1, 8'h10 + 8'(i * 7));
      chk("t6_occ", {191'h0, occ1}, 192'd1);
    end
    drive1(1'b1, 1'b0, 1'b0, 8'hx);
    chk("t6_bub_q", {184'h0, q1}, {184'h0, 8'hA5});
    chk("t6_bub_qv", {191'h0, qv1}, 192'h0);
    chk("t6_bub_occ", {191'h0, occ1}, 192'h0);
    drive1(1'b1, 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      drive1(1'b0, 1'b0, 1'b1, 8'h77);
      chk("t6_stall_q", {184'h0, q1}, {184'h0, 8'h3C});
    end
    drive1(1'b1, 1'b1, 1'b1, 8'h99);
    chk("t6_flush_q", {184'h0, q1}, {184'h0, 8'hA5});
    chk("t6_flush_qv", {191'h0, qv1}, 192'h0);
    drive1(1'b1, 1'b0, 1'b1, 8'h5A);
    #2 reset1 = 1'b0;
    #1;
    chk("t6_async_q", {184'h0, q1}, {184'h0, 8'hA5});
    chk("t6_async_qv", {191'h0, qv1}, 192'h0);
    exp1.delete();
    en1 = 1'b0;
    tick();

    chk("exp0_empty", 192'(exp0.size()), 192'h0);
    chk("exp1_empty", 192'(exp1.size()), 192'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
